// File: rtl/mem_stage_access_unit.sv
// MEM-stage access unit: turns EX/MEM register contents into data-memory req/ack accesses
// and registered writeback outputs. Optional access timeout is enabled with `define MEM_TIMEOUT_EN.
module mem_stage_access_unit #(
    parameter int DATA_W         = 16,
    parameter int RD_W           = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              in_valid,
    input  logic [15:0]       ctrl_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] store_in,
    input  logic [RD_W-1:0]   rd_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    output logic [15:0]       wb_ctrl,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                wb_valid_q, wb_valid_d;
    logic [15:0]         wb_ctrl_q, wb_ctrl_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [RD_W-1:0]     wb_rd_q, wb_rd_d;
    logic [15:0]         lat_ctrl_q, lat_ctrl_d;
    logic [RD_W-1:0]     lat_rd_q, lat_rd_d;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    always_ff @(posedge clk) begin
        if (rest) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_ctrl_q   <= '0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            lat_ctrl_q  <= '0;
            lat_rd_q    <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_ctrl_q   <= wb_ctrl_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            lat_ctrl_q  <= lat_ctrl_d;
            lat_rd_q    <= lat_rd_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    // Next-state and next-output decode; wb_valid is a one-cycle pulse by default.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wb_valid_d  = 1'b0;
        wb_ctrl_d   = wb_ctrl_q;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        lat_ctrl_d  = lat_ctrl_q;
        lat_rd_d    = lat_rd_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (ctrl_in[1:0] != 2'b00) begin
                        // A combined read+write request is treated as a write.
                        lat_ctrl_d  = ctrl_in;
                        lat_rd_d    = rd_in;
                        mem_addr_d  = alu_in;
                        mem_wdata_d = store_in;
                        mem_we_d    = ctrl_in[1];
                        mem_req_d   = 1'b1;
                        state_d     = ACCESS;
`ifdef MEM_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = alu_in;
                        wb_ctrl_d  = ctrl_in;
                        wb_rd_d    = rd_in;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_ctrl_d  = lat_ctrl_q;
                    wb_rd_d    = lat_rd_q;
                    wb_data_d  = mem_we_q ? mem_addr_q : mem_rdata;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    // Abandon the access and retire it without a register write.
                    mem_req_d  = 1'b0;
                    state_d    = IDLE;
                    err_d      = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_ctrl_d  = {lat_ctrl_q[15:3], 1'b0, lat_ctrl_q[1:0]};
                    wb_rd_d    = lat_rd_q;
                    wb_data_d  = mem_addr_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall     = (state_q == ACCESS);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_ctrl   = wb_ctrl_q;
    assign wb_data   = wb_data_q;
    assign wb_rd     = wb_rd_q;

`ifdef MEM_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Self-checking bench for mem_stage_access_unit: directed upstream/memory drivers,
// writeback scoreboard fed at issue time and drained by a monitor on wb_valid.
module tb_mem_stage_access_unit;

    localparam int DATA_W = 16;
    localparam int RD_W   = 4;
    localparam int EXP_W  = 16 + DATA_W + RD_W;

    logic              clk;
    logic              rest;
    logic              in_valid;
    logic [15:0]       ctrl_in;
    logic [DATA_W-1:0] alu_in;
    logic [DATA_W-1:0] store_in;
    logic [RD_W-1:0]   rd_in;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              wb_valid;
    logic [15:0]       wb_ctrl;
    logic [DATA_W-1:0] wb_data;
    logic [RD_W-1:0]   wb_rd;
    logic              err;

    mem_stage_access_unit #(
        .DATA_W(DATA_W),
        .RD_W(RD_W),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rest(rest),
        .in_valid(in_valid),
        .ctrl_in(ctrl_in),
        .alu_in(alu_in),
        .store_in(store_in),
        .rd_in(rd_in),
        .stall(stall),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack),
        .wb_valid(wb_valid),
        .wb_ctrl(wb_ctrl),
        .wb_data(wb_data),
        .wb_rd(wb_rd),
        .err(err)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int last_wb_cyc = 0;
    int prev_wb_cyc = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk36(input string name, input logic [EXP_W-1:0] act, input logic [EXP_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got ctrl/data/rd %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [EXP_W-1:0] pack(input logic [15:0] c, input logic [15:0] d,
                                              input logic [3:0] r);
        return {c, d, r};
    endfunction

    always @(negedge clk) begin
        if (wb_valid) begin
            prev_wb_cyc = last_wb_cyc;
            last_wb_cyc = cyc;
            chk1("wb_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) chk36("wb_entry", {wb_ctrl, wb_data, wb_rd}, exp_q.pop_front());
        end
    end

    // ---------------- memory responder ----------------
    int               ack_lat     = 0;   // 0 = never acknowledge
    logic [15:0]      rdata_val   = '0;
    logic             idle_ack_en = 1'b0;
    int               resp_cnt    = 0;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (idle_ack_en) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'hDEAD;
            end else if (mem_req) begin
                resp_cnt++;
                if (ack_lat != 0 && resp_cnt == ack_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata_val;
                end
            end else begin
                resp_cnt = 0;
            end
        end
    end

    // ---------------- upstream driver ----------------
    // Called just after a rising edge; returns just after the edge that accepted the slot.
    task automatic send(input logic [15:0] c, input logic [15:0] a, input logic [15:0] s,
                        input logic [3:0] r);
        int waited;
        in_valid = 1'b1;
        ctrl_in  = c;
        alu_in   = a;
        store_in = s;
        rd_in    = r;
        waited   = 0;
        @(negedge clk);
        while (stall && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) chk1("accept_wait", stall, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        rest     = 1'b1;
        in_valid = 1'b0;
        ctrl_in  = '0;
        alu_in   = '0;
        store_in = '0;
        rd_in    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_wb_valid", wb_valid, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk16("rst_mem_addr", mem_addr, 16'h0);
        chk16("rst_mem_wdata", mem_wdata, 16'h0);
        chk16("rst_wb_ctrl", wb_ctrl, 16'h0);
        chk16("rst_wb_data", wb_data, 16'h0);
        chk16("rst_wb_rd", {12'h0, wb_rd}, 16'h0);
        @(posedge clk);
        #1;
        rest = 1'b0;
        idle(2);

        // ALU pass-through
        exp_q.push_back(pack(16'h0004, 16'h1234, 4'd5));
        send(16'h0004, 16'h1234, 16'h0, 4'd5);
        @(negedge clk);
        chk1("alu_wb_valid", wb_valid, 1'b1);
        chk1("alu_stall", stall, 1'b0);
        chk1("alu_mem_req", mem_req, 1'b0);
        @(negedge clk);
        chk1("alu_single_pulse", wb_valid, 1'b0);
        idle(1);

        // Load acknowledged in the third ACCESS cycle
        ack_lat   = 3;
        rdata_val = 16'hBEEF;
        exp_q.push_back(pack(16'h0005, 16'hBEEF, 4'd3));
        send(16'h0005, 16'h0040, 16'h0, 4'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("load_req", mem_req, 1'b1);
            chk16("load_addr", mem_addr, 16'h0040);
            chk1("load_stall", stall, 1'b1);
            chk1("load_we", mem_we, 1'b0);
            chk1("load_no_wb", wb_valid, 1'b0);
        end
        @(negedge clk);
        chk1("load_stall_low", stall, 1'b0);
        chk1("load_req_low", mem_req, 1'b0);
        chk1("load_wb_valid", wb_valid, 1'b1);
        idle(2);

        // Store with immediate ack: wb_data carries the address, no register write
        ack_lat = 1;
        exp_q.push_back(pack(16'h0002, 16'h0010, 4'd7));
        send(16'h0002, 16'h0010, 16'hA5A5, 4'd7);
        @(negedge clk);
        chk1("store_req", mem_req, 1'b1);
        chk1("store_we", mem_we, 1'b1);
        chk16("store_wdata", mem_wdata, 16'hA5A5);
        chk16("store_addr", mem_addr, 16'h0010);
        @(negedge clk);
        chk1("store_wb_valid", wb_valid, 1'b1);
        chk1("store_wb_regwrite", wb_ctrl[2], 1'b0);
        idle(2);

        // Read and write both requested: write wins
        ack_lat   = 1;
        rdata_val = 16'h9999;
        exp_q.push_back(pack(16'h0007, 16'h0020, 4'd6));
        send(16'h0007, 16'h0020, 16'h1111, 4'd6);
        @(negedge clk);
        chk1("rw_we", mem_we, 1'b1);
        chk16("rw_wdata", mem_wdata, 16'h1111);
        idle(3);

        // Back-to-back: load with 2-cycle ack, ALU op held upstream meanwhile
        ack_lat   = 2;
        rdata_val = 16'h1357;
        exp_q.push_back(pack(16'h0005, 16'h1357, 4'd2));
        exp_q.push_back(pack(16'hABC4, 16'h7777, 4'd9));
        send(16'h0005, 16'h0050, 16'h0, 4'd2);
        send(16'hABC4, 16'h7777, 16'h0, 4'd9);
        idle(2);
        chk16("b2b_gap", 16'(last_wb_cyc - prev_wb_cyc), 16'd1);
        chk16("b2b_drained", 16'(exp_q.size()), 16'd0);

        // Reset during the second ACCESS cycle; a stray ack afterwards is ignored
        ack_lat = 0;
        send(16'h0005, 16'h0060, 16'h0, 4'd1);
        @(posedge clk);
        #1;
        rest = 1'b1;
        @(negedge clk);
        chk1("rstmid_pre_stall", stall, 1'b1);
        @(negedge clk);
        chk1("rstmid_stall", stall, 1'b0);
        chk1("rstmid_mem_req", mem_req, 1'b0);
        chk1("rstmid_wb_valid", wb_valid, 1'b0);
        chk16("rstmid_mem_addr", mem_addr, 16'h0);
        chk16("rstmid_wb_data", wb_data, 16'h0);
        rest = 1'b0;
        idle(1);
        @(negedge clk);
        idle_ack_en = 1'b1;
        @(negedge clk);
        idle_ack_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("stray_ack_no_wb", wb_valid, 1'b0);
            chk1("stray_ack_no_stall", stall, 1'b0);
        end
        idle(1);

`ifdef MEM_TIMEOUT_EN
        // Timeout after four unacknowledged ACCESS cycles
        ack_lat = 0;
        exp_q.push_back(pack(16'h0001, 16'h0070, 4'd4));
        send(16'h0005, 16'h0070, 16'h0, 4'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("to_req_held", mem_req, 1'b1);
            chk1("to_err_low", err, 1'b0);
        end
        @(negedge clk);
        chk1("to_req_drop", mem_req, 1'b0);
        chk1("to_err_set", err, 1'b1);
        chk1("to_wb_valid", wb_valid, 1'b1);
        idle(3);
        chk1("to_err_sticky", err, 1'b1);
        rest = 1'b1;
        idle(1);
        rest = 1'b0;
        idle(1);
`endif

        idle(3);
        chk16("final_exp_q_empty", 16'(exp_q.size()), 16'd0);
        chk1("final_err", err, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_access_unit.md
Name: mem_stage_access_unit

Overview:
- MEM-stage consumer of the EX-to-MEM pipeline register outputs (control word, ALU result/address, store data, destination register).
- Runs load/store accesses against data memory over a req/ack handshake with variable latency, and produces registered writeback-side outputs.
- Stalls the upstream pipeline register while an access is outstanding.

Parameters:
- DATA_W, 16, datapath, address and memory data width
- RD_W, 4, destination register index width
- TIMEOUT_CYCLES, 15, ACCESS-state cycles without ack before abort (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rest  in  1  synchronous active-high reset
- in_valid  in  1  upstream slot holds a real instruction (0 = bubble)
- ctrl_in  in  16  control word: bit0 mem_read, bit1 mem_write, bit2 reg_write; bits 15:3 pass through untouched
- alu_in  in  DATA_W  ALU result; also the memory address for loads/stores
- store_in  in  DATA_W  store data
- rd_in  in  RD_W  destination register index
- stall  out  1  upstream must hold its contents
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  DATA_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid when mem_ack = 1
- mem_ack  in  1  memory completion, single-cycle pulse
- wb_valid  out  1  wb_* outputs carry a result this cycle
- wb_ctrl  out  16  registered copy of the control word
- wb_data  out  DATA_W  load data or ALU result
- wb_rd  out  RD_W  destination index
- err  out  1  sticky access-timeout flag

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rest). All outputs and state are registered.
- With rest = 1 at an edge: state = IDLE; stall, mem_req, mem_we, wb_valid and err = 0; mem_addr, mem_wdata, wb_ctrl, wb_data and wb_rd = 0.
- States: IDLE, ACCESS.
- stall = 1 exactly when state = ACCESS. It is a combinational decode of the state register.
- IDLE, in_valid = 0: next edge wb_valid = 0; other wb_* outputs hold.
- IDLE, in_valid = 1, no memory op (bit0 = bit1 = 0):
  - next edge: wb_valid = 1, wb_data = alu_in, wb_ctrl = ctrl_in, wb_rd = rd_in (latency 1).
- IDLE, in_valid = 1, bit0 or bit1 set:
  - next edge: latch ctrl_in and rd_in internally; mem_addr = alu_in, mem_wdata = store_in, mem_we = bit1, mem_req = 1; state = ACCESS; wb_valid = 0.
  - If bit0 and bit1 are both set, the write wins: mem_we = 1 and no load data is captured.
- ACCESS: mem_req, mem_we, mem_addr and mem_wdata stay stable until the ack.
- ACCESS, mem_ack = 0: remain in ACCESS.
- ACCESS, mem_ack = 1, next edge:
  - mem_req = 0; state = IDLE; wb_valid = 1; wb_ctrl and wb_rd from the latched values.
  - wb_data = mem_rdata for a read; wb_data = the latched address for a write.
  - stall falls in the same cycle as wb_valid rises, so upstream advances one cycle after the ack.
- Minimum load/store latency from acceptance to wb_valid: 2 edges (ack in the first ACCESS cycle).
- mem_ack while in IDLE: ignored.
- wb_valid is high for exactly one cycle per accepted instruction; bubbles produce no pulse.
- Reset during ACCESS: the request is abandoned; mem_req = 0 after that edge; no wb_valid pulse for the aborted access.
- No arithmetic on data: values pass through at full width, with no truncation or extension.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to ACCESS and counts each ACCESS cycle with mem_ack = 0.
  - When the count reaches TIMEOUT_CYCLES without an ack: next edge mem_req = 0, state = IDLE, err = 1 (sticky until rest), and wb_valid = 1 with wb_ctrl bit2 forced to 0 so no register is written.
  - An ack arriving in the same cycle as the timeout takes priority, giving a normal completion.
- Not defined: no counter; ACCESS waits indefinitely; err is tied to 0.

Test Plan:
- ALU pass-through: in_valid = 1, ctrl_in = 0x0004, alu_in = 0x1234, rd_in = 5 -> next cycle wb_valid = 1, wb_data = 0x1234, wb_rd = 5, stall = 0, mem_req never asserted.
- Load, 3-cycle ack: ctrl_in = 0x0005, alu_in = 0x0040, rd_in = 3, memory acks on the 3rd ACCESS cycle with mem_rdata = 0xBEEF:
  - mem_req = 1 and mem_addr = 0x0040 held for 3 cycles, stall = 1 for 3 cycles;
  - then wb_valid = 1, wb_data = 0xBEEF, wb_rd = 3.
- Store: ctrl_in = 0x0002, alu_in = 0x0010, store_in = 0xA5A5, immediate ack -> mem_we = 1, mem_wdata = 0xA5A5; one cycle later wb_valid = 1 with wb_ctrl bit2 = 0.
- Back-to-back: load (2-cycle ack) followed by an ALU op held upstream -> the ALU op's wb_valid pulse appears exactly one cycle after the load's wb_valid; no result is lost or duplicated.
- Reset mid-access: assert rest during cycle 2 of ACCESS -> next edge all outputs 0 and state IDLE; a later stray mem_ack causes no wb_valid pulse.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, no ack -> after 4 ACCESS cycles mem_req = 0, err = 1, wb_valid = 1 with wb_ctrl bit2 = 0; err remains 1 until rest.
